pipe_reg_chain: RTL and testbench

//  Parametrised inter-stage pipeline register chain, the successor to the single fixed EX/MEM latch.

---
 rtl/pipe_reg_chain.sv | 64 ++++++
 tb/tb_pipe_reg_chain.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/payload pipeline register chain with per-stage stall/bubble/hold, flush, occupancy and sticky stall-order error
module pipe_reg_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1,
  parameter int STALL_W = 6,
  parameter int STAGE_IDX = 3,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}}
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic [STALL_W-1:0]           stall_in,
  input  logic                         flush_in,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         valid_out,
  output logic [DATA_W-1:0]            data_out,
  output logic [DEPTH-1:0]             stage_valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   occ_out,
  output logic                         err_out
);
  localparam int OCC_W = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v;
  logic [DATA_W-1:0] d [DEPTH];
  logic [DEPTH:0] sv;
  logic [DATA_W-1:0] sd [DEPTH+1];
  logic [DEPTH:0] win;
  logic bad;
  // source of stage k sits at index k: the chain inputs at 0, stage k-1 above
  always_comb begin
    sv = {v, valid_in};
    sd[0] = data_in;
    for (int k = 0; k < DEPTH; k++) sd[k+1] = d[k];
  end
  assign win = stall_in[STAGE_IDX+DEPTH:STAGE_IDX];
  assign bad = |(win[DEPTH:1] & ~win[DEPTH-1:0]);
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (rst_in) begin
        v[k] <= 1'b0;
        d[k] <= NOP_DATA;
      end else if (rdy_in) begin
        if (flush_in || (stall_in[STAGE_IDX+k] && !stall_in[STAGE_IDX+k+1])) begin
          v[k] <= 1'b0;
          d[k] <= NOP_DATA;
        end else if (!stall_in[STAGE_IDX+k]) begin
          v[k] <= sv[k];
          d[k] <= sv[k] ? sd[k] : NOP_DATA;
        end
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) err_out <= 1'b0;
    else if (rdy_in && bad) err_out <= 1'b1;
  end
  always_comb begin
    occ_out = '0;
    for (int k = 0; k < DEPTH; k++) occ_out = occ_out + OCC_W'(v[k]);
  end
  assign valid_out = v[DEPTH-1];
  assign data_out = d[DEPTH-1];
  assign stage_valid_out = v;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: DEPTH=1 and DEPTH=3 chains on shared inputs, checked against a stage-array reference model
module tb_pipe_reg_chain;
  logic clk = 1'b0;
  logic rst, rdy, flush, vin;
  logic [7:0] stall, din;
  logic v1, e1, v3, e3;
  logic [7:0] d1, d3;
  logic [0:0] sv1, o1;
  logic [2:0] sv3;
  logic [1:0] o3;
  int tests = 0, fails = 0;
  bit mv [2][4];
  logic [7:0] md [2][4];
  bit merr [2];

  always #5 clk = ~clk;

  pipe_reg_chain #(.DATA_W(8), .DEPTH(1), .STALL_W(6), .STAGE_IDX(3)) u1 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall_in(stall[5:0]), .flush_in(flush),
    .valid_in(vin), .data_in(din), .valid_out(v1), .data_out(d1),
    .stage_valid_out(sv1), .occ_out(o1), .err_out(e1));

  pipe_reg_chain #(.DATA_W(8), .DEPTH(3), .STALL_W(8), .STAGE_IDX(3)) u3 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall_in(stall), .flush_in(flush),
    .valid_in(vin), .data_in(din), .valid_out(v3), .data_out(d3),
    .stage_valid_out(sv3), .occ_out(o3), .err_out(e3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the behavioural model: stage k sees stop bit 3+k and the downstream stop bit 3+k+1
  task automatic step_model();
    for (int i = 0; i < 2; i++) begin
      int dep = (i == 0) ? 1 : 3;
      if (rst) begin
        for (int k = 0; k < 4; k++) begin mv[i][k] = 0; md[i][k] = 8'h00; end
        merr[i] = 0;
      end else if (rdy) begin
        for (int j = 1; j <= dep; j++)
          if (stall[3+j] && !stall[3+j-1]) merr[i] = 1;
        for (int k = dep - 1; k >= 0; k--) begin
          bit sk = stall[3+k], sn = stall[3+k+1];
          bit srcv = (k == 0) ? vin : mv[i][k-1];
          logic [7:0] srcd = (k == 0) ? din : md[i][k-1];
          if (flush || (sk && !sn)) begin mv[i][k] = 0; md[i][k] = 8'h00; end
          else if (!sk) begin mv[i][k] = srcv; md[i][k] = srcv ? srcd : 8'h00; end
        end
      end
    end
  endtask

  task automatic cycle();
    int occ;
    logic [2:0] vec;
    @(posedge clk);
    step_model();
    #1;
    chk("u1.valid", v1, mv[0][0]);
    chk("u1.data", d1, md[0][0]);
    chk("u1.stage_valid", sv1, mv[0][0]);
    chk("u1.occ", o1, mv[0][0]);
    chk("u1.err", e1, merr[0]);
    occ = 0;
    for (int k = 0; k < 3; k++) begin vec[k] = mv[1][k]; occ += int'(mv[1][k]); end
    chk("u3.valid", v3, mv[1][2]);
    chk("u3.data", d3, md[1][2]);
    chk("u3.stage_valid", sv3, vec);
    chk("u3.occ", o3, occ);
    chk("u3.err", e3, merr[1]);
  endtask

  task automatic drive(input logic r, input logic y, input logic f, input logic [7:0] s,
                       input logic v, input logic [7:0] d);
    rst = r; rdy = y; flush = f; stall = s; vin = v; din = d;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      merr[i] = 0;
      for (int k = 0; k < 4; k++) begin mv[i][k] = 0; md[i][k] = 8'h00; end
    end
    drive(1, 1, 0, 8'h00, 1, 8'h5A);
    cycle(); cycle();
    chk("reset.u3.occ", o3, 0);
    // streaming: one-cycle latency on DEPTH=1, three on DEPTH=3
    drive(0, 1, 0, 8'h00, 1, 8'h11); cycle(); chk("t1.0x11", d1, 8'h11);
    drive(0, 1, 0, 8'h00, 1, 8'h22); cycle(); chk("t1.0x22", d1, 8'h22);
    drive(0, 1, 0, 8'h00, 1, 8'h33); cycle(); chk("t1.0x33", d1, 8'h33);
    chk("t1.u3.0x11", d3, 8'h11);
    // bubble: stop own bit, downstream free
    drive(0, 1, 0, 8'h00, 1, 8'hAB); cycle();
    drive(0, 1, 0, 8'h08, 1, 8'hCD); cycle();
    chk("t2.valid", v1, 0); chk("t2.nop", d1, 8'h00); chk("t2.occ", o1, 0);
    // hold: own and downstream stopped for three cycles
    drive(0, 1, 0, 8'h00, 1, 8'hAB); cycle();
    for (int n = 0; n < 3; n++) begin
      drive(0, 1, 0, 8'h18, 1, 8'hEE); cycle();
      chk("t3.hold", d1, 8'hAB); chk("t3.valid", v1, 1);
    end
    drive(0, 1, 0, 8'h00, 1, 8'h77); cycle(); chk("t3.release", d1, 8'h77);
    // flush with DEPTH=3 after the third of a 1..5 stream
    for (int n = 1; n <= 3; n++) begin drive(0, 1, 0, 8'h00, 1, 8'(n)); cycle(); end
    drive(0, 1, 1, 8'h00, 1, 8'h04); cycle();
    chk("t4.stage_valid", sv3, 3'b000); chk("t4.occ", o3, 0);
    drive(0, 1, 0, 8'h00, 1, 8'h04); cycle();
    drive(0, 1, 0, 8'h00, 1, 8'h05); cycle();
    drive(0, 1, 0, 8'h00, 0, 8'h00); cycle();
    chk("t4.0x4", d3, 8'h04); chk("t4.0x4v", v3, 1);
    // frozen while not ready, even with flush asserted
    drive(0, 0, 1, 8'h00, 1, 8'h99); cycle(); cycle();
    chk("t5.frozen", d3, 8'h04);
    drive(0, 1, 0, 8'h00, 1, 8'h66); cycle();
    chk("t5.resume", d3, 8'h05);
    // non-monotonic stall window sets sticky error; flush keeps it
    drive(0, 1, 0, 8'h10, 1, 8'h01); cycle();
    chk("t6.err1", e1, 1); chk("t6.err3", e3, 1);
    drive(0, 1, 1, 8'h00, 0, 8'h00); cycle();
    chk("t6.sticky", e3, 1);
    drive(1, 1, 0, 8'h00, 0, 8'h00); cycle();
    chk("t6.clear", e3, 0);
    // randomized traffic, mostly legal stall windows
    for (int n = 0; n < 600; n++) begin
      logic [7:0] s;
      int w = $urandom_range(0, 5);
      s = 8'(((1 << w) - 1) << 3) | 8'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) s = 8'($urandom);
      if ($urandom_range(0, 2) != 0) s[7:3] = 5'b0;
      drive($urandom_range(0, 60) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 20) == 0,
            s, 1'($urandom), 8'($urandom));
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
